// File: rtl/dp_result_writer_if.sv
// Byte-wide AXI-style write channel (AW, W, B) between dp_result_writer and the result memory.
interface dp_result_writer_if;
   logic [31:0] MEM_AWADDR;
   logic        MEM_AWVALID;
   logic        MEM_AWREADY;
   logic [7:0]  MEM_WDATA;
   logic        MEM_WVALID;
   logic        MEM_WREADY;
   logic        MEM_BVALID;
   logic        MEM_BREADY;

   modport master (
      output MEM_AWADDR, MEM_AWVALID, MEM_WDATA, MEM_WVALID, MEM_BREADY,
      input  MEM_AWREADY, MEM_WREADY, MEM_BVALID
   );

   modport slave (
      input  MEM_AWADDR, MEM_AWVALID, MEM_WDATA, MEM_WVALID, MEM_BREADY,
      output MEM_AWREADY, MEM_WREADY, MEM_BVALID
   );
endinterface

// File: rtl/dp_result_writer.sv
// Buffers dot-product results in a FIFO and logs each one as four little-endian byte writes.
// Optional macro WB_IRQ_EN enables the one-cycle done_irq pulse per completed result.
module dp_result_writer #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0040,
   parameter int unsigned REGION_BYTES = 64
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [31:0]                   DP_RESULT,
   input  logic                          DP_DONE,
   input  logic                          wr_clear,
   dp_result_writer_if.master            mem,
   output logic [15:0]                   results_written,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          busy,
   output logic                          done_irq
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;

   state_t            r_state, w_state_nxt;
   logic [31:0]       r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_done_q, r_clear_pend, r_overflow;
   logic [1:0]        r_byte_idx;
   logic [31:0]       r_offset;
   logic [15:0]       r_written;
   logic [31:0]       r_awaddr;
   logic [7:0]        r_wdata;
   logic              r_awvalid, r_wvalid;

   logic              w_push, w_push_ok, w_full, w_empty, w_pop;
   logic              w_start, w_next_byte, w_result_done, w_apply_clear, w_bready;
   logic              w_aw_ok, w_w_ok, w_load, w_wr_en;
   logic [1:0]        w_load_idx;
   logic [PTR_W-1:0]  w_wr_idx;
   logic [31:0]       w_head, w_offset_inc, w_offset_nxt;

   assign w_push       = DP_DONE & ~r_done_q;
   assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty      = (r_level == '0);
   assign w_head       = r_fifo[r_rd_ptr];
   assign w_aw_ok      = ~r_awvalid | mem.MEM_AWREADY;
   assign w_w_ok       = ~r_wvalid | mem.MEM_WREADY;
   assign w_pop        = w_result_done;
   assign w_push_ok    = w_push & (~w_full | w_pop);
   assign w_load       = w_start | w_next_byte;
   assign w_load_idx   = w_next_byte ? r_byte_idx + 2'd1 : r_byte_idx;
   assign w_offset_inc = r_offset + 32'd4;
   assign w_offset_nxt = (w_offset_inc == REGION_BYTES) ? '0 : w_offset_inc;

   // A flush keeps the read pointer, so a push in the clear cycle becomes the sole entry there.
   assign w_wr_en  = w_apply_clear ? w_push : w_push_ok;
   assign w_wr_idx = w_apply_clear ? r_rd_ptr : r_wr_ptr;

   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (!w_empty && !r_clear_pend) w_state_nxt = S_XFER;
         S_XFER:  if (w_aw_ok && w_w_ok) w_state_nxt = S_RESP;
         S_RESP:  if (mem.MEM_BVALID) w_state_nxt = (r_byte_idx == 2'd3) ? S_IDLE : S_XFER;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_start       = 1'b0;
      w_next_byte   = 1'b0;
      w_result_done = 1'b0;
      w_apply_clear = 1'b0;
      w_bready      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_apply_clear = r_clear_pend;
            w_start       = !w_empty && !r_clear_pend;
         end
         S_RESP: begin
            w_bready      = 1'b1;
            w_next_byte   = mem.MEM_BVALID && (r_byte_idx != 2'd3);
            w_result_done = mem.MEM_BVALID && (r_byte_idx == 2'd3);
         end
         default: ;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (w_wr_en) r_fifo[w_wr_idx] <= DP_RESULT;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_overflow   <= 1'b0;
         r_done_q     <= 1'b0;
         r_clear_pend <= 1'b0;
      end else begin
         r_done_q     <= DP_DONE;
         r_clear_pend <= wr_clear | (r_clear_pend & ~w_apply_clear);
         if (w_apply_clear) begin
            r_wr_ptr   <= r_rd_ptr + PTR_W'(w_push);
            r_level    <= LVL_W'(w_push);
            r_overflow <= 1'b0;
         end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
            r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_byte_idx <= '0;
         r_offset   <= '0;
         r_written  <= '0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
      end else begin
         if (w_apply_clear) begin
            r_offset  <= '0;
            r_written <= '0;
         end
         if (w_load) begin
            r_awaddr   <= BASE_ADDR + r_offset + 32'(w_load_idx);
            r_wdata    <= w_head[8*w_load_idx +: 8];
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_byte_idx <= w_load_idx;
         end else if (r_state == S_XFER) begin
            if (mem.MEM_AWREADY) r_awvalid <= 1'b0;
            if (mem.MEM_WREADY)  r_wvalid  <= 1'b0;
         end
         if (w_result_done) begin
            r_byte_idx <= '0;
            r_offset   <= w_offset_nxt;
            r_written  <= r_written + 16'd1;
         end
      end
   end

`ifdef WB_IRQ_EN
   logic r_done_irq;
   always_ff @(posedge ACLK) begin
      if (ARESET) r_done_irq <= 1'b0;
      else        r_done_irq <= w_result_done;
   end
   assign done_irq = r_done_irq;
`else
   assign done_irq = 1'b0;
`endif

   assign mem.MEM_AWADDR  = r_awaddr;
   assign mem.MEM_AWVALID = r_awvalid;
   assign mem.MEM_WDATA   = r_wdata;
   assign mem.MEM_WVALID  = r_wvalid;
   assign mem.MEM_BREADY  = w_bready;
   assign results_written = r_written;
   assign fifo_level      = r_level;
   assign overflow        = r_overflow;
   assign busy            = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_dp_result_writer.sv
// Self-checking bench for dp_result_writer: randomized results against a byte-log reference model.
module tb_dp_result_writer;
   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] BASE   = 32'h0000_0040;
   localparam int unsigned REGION = 64;
`ifdef WB_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dp_result;
   logic        dp_done, wr_clear;
   logic [15:0] results_written;
   logic [2:0]  fifo_level;
   logic        overflow, busy, done_irq;

   dp_result_writer_if mem_if ();

   dp_result_writer #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .REGION_BYTES(REGION)) dut (
      .ACLK(clk), .ARESET(rst), .DP_RESULT(dp_result), .DP_DONE(dp_done), .wr_clear(wr_clear),
      .mem(mem_if), .results_written(results_written), .fifo_level(fifo_level),
      .overflow(overflow), .busy(busy), .done_irq(done_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // memory slave configuration and observed bus log
   int          aw_delay = 0, w_delay = 0;
   bit          hold_aw = 1'b0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, irq_cnt = 0, stab_err = 0;
   bit          aw_wait = 1'b0, w_wait = 1'b0;
   logic [31:0] prev_addr;
   logic [7:0]  prev_data;
   logic [31:0] aw_log [$];
   logic [7:0]  w_log [$];

   // reference model: expected byte writes, ring offset and completed-result count
   logic [31:0] exp_addr [$];
   logic [7:0]  exp_data [$];
   int          m_off = 0;
   int          m_written = 0;

   initial begin
      mem_if.MEM_AWREADY = 1'b0;
      mem_if.MEM_WREADY  = 1'b0;
      mem_if.MEM_BVALID  = 1'b0;
      forever begin
         @(negedge clk); #1;
         if (rst) begin
            mem_if.MEM_AWREADY = 1'b0;
            mem_if.MEM_WREADY  = 1'b0;
            mem_if.MEM_BVALID  = 1'b0;
            aw_cnt = 0; w_cnt = 0; aw_wait = 1'b0; w_wait = 1'b0;
         end else begin
            if (aw_wait && (mem_if.MEM_AWVALID !== 1'b1 || mem_if.MEM_AWADDR !== prev_addr)) stab_err++;
            if (w_wait && (mem_if.MEM_WVALID !== 1'b1 || mem_if.MEM_WDATA !== prev_data)) stab_err++;
            if (mem_if.MEM_AWVALID) begin
               mem_if.MEM_AWREADY = !hold_aw && (aw_cnt >= aw_delay);
               aw_cnt++;
            end else begin
               mem_if.MEM_AWREADY = 1'b0;
               aw_cnt = 0;
            end
            if (mem_if.MEM_WVALID) begin
               mem_if.MEM_WREADY = (w_cnt >= w_delay);
               w_cnt++;
            end else begin
               mem_if.MEM_WREADY = 1'b0;
               w_cnt = 0;
            end
            mem_if.MEM_BVALID = mem_if.MEM_BREADY;
            if (mem_if.MEM_AWVALID && mem_if.MEM_AWREADY) aw_log.push_back(mem_if.MEM_AWADDR);
            if (mem_if.MEM_WVALID && mem_if.MEM_WREADY) w_log.push_back(mem_if.MEM_WDATA);
            if (mem_if.MEM_BVALID && mem_if.MEM_BREADY) b_cnt++;
            if (done_irq) irq_cnt++;
            aw_wait   = mem_if.MEM_AWVALID && !mem_if.MEM_AWREADY;
            w_wait    = mem_if.MEM_WVALID && !mem_if.MEM_WREADY;
            prev_addr = mem_if.MEM_AWADDR;
            prev_data = mem_if.MEM_WDATA;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_result(input logic [31:0] v);
      for (int unsigned k = 0; k < 4; k++) begin
         exp_addr.push_back(BASE + 32'(m_off) + 32'(k));
         exp_data.push_back(v[8*k +: 8]);
      end
      m_off     = (m_off + 4) % REGION;
      m_written = (m_written + 1) % 65536;
   endtask

   function automatic int log_mismatches();
      int n = 0;
      if (aw_log.size() != exp_addr.size()) n++;
      if (w_log.size() != exp_data.size()) n++;
      for (int i = 0; i < exp_addr.size() && i < aw_log.size(); i++)
         if (aw_log[i] !== exp_addr[i]) n++;
      for (int i = 0; i < exp_data.size() && i < w_log.size(); i++)
         if (w_log[i] !== exp_data[i]) n++;
      return n;
   endfunction

   function automatic int exp_irq();
      return IRQ_EN ? exp_addr.size() / 4 : 0;
   endfunction

   task automatic clear_log();
      aw_log.delete(); w_log.delete(); exp_addr.delete(); exp_data.delete();
      b_cnt = 0; irq_cnt = 0; stab_err = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      m_off = 0;
      m_written = 0;
      cyc(1);
      clear_log();
   endtask

   task automatic pulse_done(input logic [31:0] v, input int hold);
      dp_result = v;
      dp_done   = 1'b1;
      cyc(hold);
      dp_done   = 1'b0;
      cyc(1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      cyc(1);
      while (busy !== 1'b0 && n < budget) begin
         cyc(1);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; dp_done = 1'b0; wr_clear = 1'b0; dp_result = '0;
      cyc(3);
      checks++;
      if ({mem_if.MEM_AWADDR, mem_if.MEM_AWVALID, mem_if.MEM_WDATA, mem_if.MEM_WVALID, mem_if.MEM_BREADY} !== '0) begin
         errors++;
         $display("FAIL reset_bus: awaddr=%h awv=%b wdata=%h wv=%b bready=%b, required all 0",
                  mem_if.MEM_AWADDR, mem_if.MEM_AWVALID, mem_if.MEM_WDATA, mem_if.MEM_WVALID, mem_if.MEM_BREADY);
      end
      checks++;
      if ({results_written, fifo_level, overflow, busy, done_irq} !== '0) begin
         errors++;
         $display("FAIL reset_status: written=%0d level=%0d ovf=%b busy=%b irq=%b, required all 0",
                  results_written, fifo_level, overflow, busy, done_irq);
      end
      rst = 1'b0;
      cyc(1);
      clear_log();
   endtask

   task automatic test_single();
      logic [31:0] v = 32'hA1B2C3D4;
      aw_delay = 0; w_delay = 0; hold_aw = 1'b0;
      model_result(v);
      dp_result = v;
      dp_done   = 1'b1;
      cyc(1);
      checks++;
      if (fifo_level !== 3'd1 || mem_if.MEM_AWVALID !== 1'b0) begin
         errors++;
         $display("FAIL single_capture: level=%0d awv=%b, required level=1 awv=0", fifo_level, mem_if.MEM_AWVALID);
      end
      cyc(1);
      checks++;
      if (mem_if.MEM_AWVALID !== 1'b1 || mem_if.MEM_WVALID !== 1'b1 ||
          mem_if.MEM_AWADDR !== 32'h40 || mem_if.MEM_WDATA !== 8'hD4) begin
         errors++;
         $display("FAIL single_first_byte: awv=%b wv=%b addr=%h data=%h, required 1 1 00000040 d4",
                  mem_if.MEM_AWVALID, mem_if.MEM_WVALID, mem_if.MEM_AWADDR, mem_if.MEM_WDATA);
      end
      cyc(1);
      dp_done = 1'b0;
      wait_idle("single", 100);
      checks++;
      if (log_mismatches() !== 0) begin
         errors++;
         $display("FAIL single_writes: %0d mismatches (got %0d writes, required %0d)", log_mismatches(), aw_log.size(), exp_addr.size());
      end
      checks++;
      if (results_written !== 16'(m_written) || b_cnt !== 4) begin
         errors++;
         $display("FAIL single_count: written=%0d b=%0d, required %0d and 4", results_written, b_cnt, m_written);
      end
      checks++;
      if (irq_cnt !== exp_irq()) begin
         errors++;
         $display("FAIL single_irq: pulses=%0d, required %0d", irq_cnt, exp_irq());
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] v;
      clear_log();
      for (int i = 0; i < 6; i++) begin
         if (i == 0)      begin aw_delay = 3; w_delay = 0; end
         else if (i == 1) begin aw_delay = 0; w_delay = 3; end
         else             begin aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4); end
         v = $urandom;
         model_result(v);
         pulse_done(v, 1);
         wait_idle("backpressure", 300);
      end
      aw_delay = 0; w_delay = 0;
      checks++;
      if (log_mismatches() !== 0) begin
         errors++;
         $display("FAIL backpressure_writes: %0d mismatches (got %0d writes, required %0d)", log_mismatches(), aw_log.size(), exp_addr.size());
      end
      checks++;
      if (stab_err !== 0) begin
         errors++;
         $display("FAIL backpressure_stable: %0d changes while valid, required 0", stab_err);
      end
      checks++;
      if (results_written !== 16'(m_written) || irq_cnt !== exp_irq()) begin
         errors++;
         $display("FAIL backpressure_count: written=%0d irq=%0d, required %0d and %0d", results_written, irq_cnt, m_written, exp_irq());
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      clear_log();
      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         model_result(v);
         pulse_done(v, 1);
      end
      wait_idle("back_to_back", 300);
      checks++;
      if (log_mismatches() !== 0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back_writes: %0d mismatches ovf=%b, required 0 mismatches ovf=0", log_mismatches(), overflow);
      end
      checks++;
      if (results_written !== 16'(m_written) || irq_cnt !== exp_irq()) begin
         errors++;
         $display("FAIL back_to_back_count: written=%0d irq=%0d, required %0d and %0d", results_written, irq_cnt, m_written, exp_irq());
      end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      bit found = 1'b0;
      do_reset();
      hold_aw = 1'b1;
      for (int i = 0; i < 5; i++) begin
         v = $urandom;
         if (i < DEPTH) model_result(v);
         pulse_done(v, $urandom_range(1, 3));
      end
      checks++;
      if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_full: level=%0d ovf=%b, required 4 and 1", fifo_level, overflow);
      end
      hold_aw = 1'b0;
      // push exactly on the cycle the head result pops
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk); #2;
         if (mem_if.MEM_BVALID && mem_if.MEM_BREADY && b_cnt == 4) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL overflow_pop_wait: 4th B handshake not seen, required within 200 cycles");
      end
      v = $urandom;
      model_result(v);
      dp_result = v;
      dp_done   = 1'b1;
      @(negedge clk);
      dp_done   = 1'b0;
      checks++;
      if (fifo_level !== 3'd4) begin
         errors++;
         $display("FAIL overflow_push_on_pop: level=%0d, required 4", fifo_level);
      end
      wait_idle("overflow", 400);
      checks++;
      if (log_mismatches() !== 0 || stab_err !== 0) begin
         errors++;
         $display("FAIL overflow_writes: %0d mismatches stab=%0d (got %0d writes, required %0d)",
                  log_mismatches(), stab_err, aw_log.size(), exp_addr.size());
      end
      checks++;
      if (results_written !== 16'(m_written) || overflow !== 1'b1 || irq_cnt !== exp_irq()) begin
         errors++;
         $display("FAIL overflow_count: written=%0d ovf=%b irq=%0d, required %0d 1 %0d",
                  results_written, overflow, irq_cnt, m_written, exp_irq());
      end
   endtask

   task automatic test_clear();
      logic [31:0] r1, r2, r3, r4;
      clear_log();
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
      model_result(r1);
      model_result(r2);
      pulse_done(r1, 1);
      pulse_done(r2, 1);
      pulse_done(r3, 1);
      for (int n = 0; n < 300 && aw_log.size() < 5; n++) cyc(1);
      wr_clear = 1'b1;
      cyc(1);
      wr_clear = 1'b0;
      wait_idle("clear", 300);
      checks++;
      if (results_written !== 16'd0 || overflow !== 1'b0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL clear_state: written=%0d ovf=%b level=%0d, required 0 0 0", results_written, overflow, fifo_level);
      end
      m_off = 0;
      m_written = 0;
      model_result(r4);
      pulse_done(r4, 2);
      wait_idle("clear_after", 100);
      checks++;
      if (log_mismatches() !== 0) begin
         errors++;
         $display("FAIL clear_writes: %0d mismatches (got %0d writes, required %0d)", log_mismatches(), aw_log.size(), exp_addr.size());
      end
      checks++;
      if (results_written !== 16'(m_written) || irq_cnt !== exp_irq()) begin
         errors++;
         $display("FAIL clear_count: written=%0d irq=%0d, required %0d and %0d", results_written, irq_cnt, m_written, exp_irq());
      end
   endtask

   task automatic test_wrap();
      logic [31:0] v;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         aw_delay = $urandom_range(0, 2);
         w_delay  = $urandom_range(0, 2);
         v = $urandom;
         model_result(v);
         pulse_done(v, $urandom_range(1, 3));
         wait_idle("wrap", 200);
      end
      aw_delay = 0; w_delay = 0;
      checks++;
      if (aw_log.size() < 68 || aw_log[64] !== BASE) begin
         errors++;
         $display("FAIL wrap_17th_addr: writes=%0d addr=%h, required 68 writes and 00000040",
                  aw_log.size(), (aw_log.size() > 64) ? aw_log[64] : 32'hFFFF_FFFF);
      end
      checks++;
      if (log_mismatches() !== 0) begin
         errors++;
         $display("FAIL wrap_writes: %0d mismatches (got %0d writes, required %0d)", log_mismatches(), aw_log.size(), exp_addr.size());
      end
      checks++;
      if (results_written !== 16'd17 || irq_cnt !== exp_irq()) begin
         errors++;
         $display("FAIL wrap_count: written=%0d irq=%0d, required 17 and %0d", results_written, irq_cnt, exp_irq());
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      clear_log();
      hold_aw = 1'b1;
      pulse_done($urandom, 1);
      for (int n = 0; n < 20 && !seen; n++) begin
         if (mem_if.MEM_AWVALID === 1'b1) seen = 1'b1;
         else cyc(1);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL reset_mid_start: awvalid never rose, required 1 within 20 cycles");
      end
      rst = 1'b1;
      cyc(1);
      checks++;
      if ({mem_if.MEM_AWADDR, mem_if.MEM_AWVALID, mem_if.MEM_WDATA, mem_if.MEM_WVALID, mem_if.MEM_BREADY,
           results_written, fifo_level, overflow, busy, done_irq} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: awv=%b wv=%b addr=%h level=%0d busy=%b written=%0d, required all 0",
                  mem_if.MEM_AWVALID, mem_if.MEM_WVALID, mem_if.MEM_AWADDR, fifo_level, busy, results_written);
      end
      rst = 1'b0;
      hold_aw = 1'b0;
      cyc(5);
      checks++;
      if (mem_if.MEM_AWVALID !== 1'b0 || busy !== 1'b0 || irq_cnt !== 0) begin
         errors++;
         $display("FAIL reset_mid_after: awv=%b busy=%b irq=%0d, required 0 0 0", mem_if.MEM_AWVALID, busy, irq_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_clear();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
